// File: rtl/display_scan_ctrl.sv
// 4-digit 7-segment scan controller: digit select, nibble mux,
// per-slot dead-time blanking, and a frame-synchronous double-buffered value.
//
// Ports:
//   clk, rst        rising-edge clock, async active-high reset
//   load            1-cycle strobe capturing data_in / blank_in
//   data_in[15:0]   four nibbles, digit k = data_in[4k+3:4k]
//   blank_in[3:0]   per-digit blank, 1 = dark
//   sel[1:0]        scanned digit index (to 2-to-4 decoder)
//   nibble[3:0]     shadow nibble of digit sel
//   digit_en        selected digit lit (not dead time, not blanked)
//   frame_end       1-cycle pulse on the first cycle of each frame
//   pending         captured value waiting for the frame boundary
module display_scan_ctrl #(
  parameter int unsigned DIV  = 100000,
  parameter int unsigned DEAD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [3:0]  blank_in,
  output logic [1:0]  sel,
  output logic [3:0]  nibble,
  output logic        digit_en,
  output logic        frame_end,
  output logic        pending
);

  localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] DEADC = CW'(DEAD);

  typedef enum logic {
    S_DEAD,
    S_ON
  } slot_e;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [15:0]   shadow_data_q, shadow_data_d;
  logic [3:0]    shadow_blank_q, shadow_blank_d;
  logic [15:0]   pend_data_q, pend_data_d;
  logic [3:0]    pend_blank_q, pend_blank_d;
  logic          pend_q, pend_d;
  logic          frame_end_q, frame_end_d;

  logic          slot_end;
  logic          boundary;
  slot_e         slot;
  logic [3:0]    nib_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      sel_q          <= '0;
      shadow_data_q  <= '0;
      shadow_blank_q <= 4'hF;
      pend_data_q    <= '0;
      pend_blank_q   <= 4'hF;
      pend_q         <= 1'b0;
      frame_end_q    <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      sel_q          <= sel_d;
      shadow_data_q  <= shadow_data_d;
      shadow_blank_q <= shadow_blank_d;
      pend_data_q    <= pend_data_d;
      pend_blank_q   <= pend_blank_d;
      pend_q         <= pend_d;
      frame_end_q    <= frame_end_d;
    end
  end

  assign slot_end = (cnt_q == LAST);
  assign boundary = slot_end && (sel_q == 2'd3);

  always_comb begin
    cnt_d          = cnt_q + CW'(1);
    sel_d          = sel_q;
    shadow_data_d  = shadow_data_q;
    shadow_blank_d = shadow_blank_q;
    pend_data_d    = pend_data_q;
    pend_blank_d   = pend_blank_q;
    pend_d         = pend_q;
    frame_end_d    = boundary;

    if (slot_end) begin
      cnt_d = '0;
      sel_d = sel_q + 2'd1;
    end

    // A load on the boundary bypasses the pending buffer and
    // supersedes anything already waiting there.
    if (boundary) begin
      if (load) begin
        shadow_data_d  = data_in;
        shadow_blank_d = blank_in;
      end else if (pend_q) begin
        shadow_data_d  = pend_data_q;
        shadow_blank_d = pend_blank_q;
      end
      pend_d = 1'b0;
    end else if (load) begin
      pend_data_d  = data_in;
      pend_blank_d = blank_in;
      pend_d       = 1'b1;
    end
  end

  assign slot     = (cnt_q < DEADC) ? S_DEAD : S_ON;
  assign nib_idx  = {sel_q, 2'b00};

  assign sel       = sel_q;
  assign nibble    = shadow_data_q[nib_idx +: 4];
  assign digit_en  = (slot == S_ON) && !shadow_blank_q[sel_q];
  assign frame_end = frame_end_q;
  assign pending   = pend_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (DIV=8, DEAD=2):
// cycle-indexed reference model plus directed and random stimulus.
module tb_display_scan_ctrl;

  localparam int DIV  = 8;
  localparam int DEAD = 2;
  localparam int FRM  = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  blank_in = '0;
  logic [1:0]  sel;
  logic [3:0]  nibble;
  logic        digit_en;
  logic        frame_end;
  logic        pending;

  int errors = 0;
  int checks = 0;

  display_scan_ctrl #(.DIV(DIV), .DEAD(DEAD)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .data_in  (data_in),
    .blank_in (blank_in),
    .sel      (sel),
    .nibble   (nibble),
    .digit_en (digit_en),
    .frame_end(frame_end),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: t = cycles since reset release. The value shown
  // during a frame is the most recent load made before that frame began.
  int          t = 0;
  bit          have = 0;
  int          lastc = 0;
  logic [15:0] lastd = '0;
  logic [3:0]  lastb = '0;
  logic [15:0] shownd = '0;
  logic [3:0]  shownb = 4'hF;

  initial begin
    forever begin
      int msel;
      @(negedge clk);
      if (rst) begin
        t = 0; have = 0;
        shownd = '0; shownb = 4'hF;
      end
      msel = (t / DIV) % 4;
      chk("sel", 32'(sel), 32'(msel));
      chk("nibble", 32'(nibble), 32'((shownd >> (4 * msel)) & 16'hF));
      chk("digit_en", 32'(digit_en),
          32'(((t % DIV) >= DEAD) && !shownb[msel]));
      chk("frame_end", 32'(frame_end), 32'((t > 0) && (t % FRM == 0)));
      chk("pending", 32'(pending),
          32'(have && (lastc >= FRM * (t / FRM))));
      if (!rst) begin
        if (load) begin
          have = 1; lastc = t;
          lastd = data_in; lastb = blank_in;
        end
        t++;
        if (t % FRM == 0 && have) begin
          shownd = lastd; shownb = lastb;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_cyc(input int c);
    for (int i = 0; i < 2000 && t < c; i++) step();
  endtask

  task automatic do_load(input int c, input logic [15:0] d,
                         input logic [3:0] b);
    wait_cyc(c);
    load = 1'b1; data_in = d; blank_in = b;
    step();
    load = 1'b0;
  endtask

  task automatic peek(input int c);
    wait_cyc(c);
    #1;
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b0;

    // Free run, all blank, then a mid-frame load.
    do_load(75, 16'h1234, 4'h0);
    chk("lit_pend_after_load", 32'(pending), 32'd1);
    chk("lit_nib_still_old", 32'(nibble), 32'd0);
    peek(96);
    chk("lit_frame_end", 32'(frame_end), 32'd1);
    chk("lit_dead_en", 32'(digit_en), 32'd0);
    chk("lit_pend_clear", 32'(pending), 32'd0);
    peek(98);
    chk("lit_nib0", 32'(nibble), 32'h4);
    chk("lit_on_en", 32'(digit_en), 32'd1);
    peek(107);
    chk("lit_nib1", 32'(nibble), 32'h3);

    // Last load within a frame wins.
    do_load(130, 16'hAAAA, 4'h0);
    do_load(140, 16'h5555, 4'h0);
    chk("lit_pend_two", 32'(pending), 32'd1);
    peek(170);
    chk("lit_last_wins", 32'(nibble), 32'h5);

    // Load exactly on the frame boundary.
    do_load(191, 16'hBEEF, 4'b0100);
    #1;
    chk("lit_bnd_nib", 32'(nibble), 32'hF);
    chk("lit_bnd_pend", 32'(pending), 32'd0);
    peek(212);
    chk("lit_bnd_sel", 32'(sel), 32'd2);
    chk("lit_bnd_blank", 32'(digit_en), 32'd0);
    chk("lit_bnd_nib2", 32'(nibble), 32'hE);

    // Pending value lost to an asynchronous reset.
    do_load(220, 16'h9876, 4'h0);
    wait_cyc(230);
    rst = 1'b1;
    #1;
    chk("lit_rst_sel", 32'(sel), 32'd0);
    chk("lit_rst_nib", 32'(nibble), 32'd0);
    chk("lit_rst_en", 32'(digit_en), 32'd0);
    chk("lit_rst_pend", 32'(pending), 32'd0);
    chk("lit_rst_fe", 32'(frame_end), 32'd0);
    repeat (3) step();
    rst = 1'b0;
    peek(42);
    chk("lit_post_rst_en", 32'(digit_en), 32'd0);
    chk("lit_post_rst_nib", 32'(nibble), 32'd0);

    // Random traffic with occasional resets.
    repeat (800) begin
      step();
      load     = ($urandom_range(0, 7) == 0);
      data_in  = 16'($urandom);
      blank_in = 4'($urandom);
      rst      = ($urandom_range(0, 299) == 0);
    end
    load = 1'b0;
    rst  = 1'b0;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
